// File: rtl/systolic_pkg.sv
// rtl/systolic_pkg.sv - shared defaults, word type and FSM states for the systolic feeder
package systolic_pkg;

   localparam int DEF_N = 32;
   localparam int DEF_M = 3;
   localparam int DEF_Q = 10;

   typedef logic signed [DEF_N-1:0] word_t;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_STREAM = 2'd1,
      ST_FLUSH  = 2'd2,
      ST_DONE   = 2'd3
   } state_t;

endpackage

// File: rtl/skew_line.sv
// rtl/skew_line.sv - DEPTH-stage shift line that advances only on shift
module skew_line #(
   parameter int DEPTH = 1,
   parameter int N     = 32
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                shift,
   input  logic signed [N-1:0] d,
   output logic signed [N-1:0] q
);

   logic signed [N-1:0] stage_q [DEPTH];
   logic signed [N-1:0] stage_d [DEPTH];

   // shift one stage toward the output when enabled, otherwise hold every stage
   always_comb begin
      stage_d = stage_q;
      if (shift) begin
         stage_d[0] = d;
         for (int s = 1; s < DEPTH; s++) begin
            stage_d[s] = stage_q[s-1];
         end
      end
   end

   // stage registers, cleared asynchronously so in-flight data is discarded on reset
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int s = 0; s < DEPTH; s++) begin
            stage_q[s] <= '0;
         end
      end else begin
         stage_q <= stage_d;
      end
   end

   assign q = stage_q[DEPTH-1];

endmodule

// File: rtl/systolic_feeder.sv
// rtl/systolic_feeder.sv - skews A columns / B rows onto the edges of an MxM systolic array
module systolic_feeder
   import systolic_pkg::*;
#(
   parameter int N = DEF_N,
   parameter int M = DEF_M,
   parameter int Q = DEF_Q
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic                  in_last,
   input  logic [M-1:0][N-1:0]   a_col,
   input  logic [M-1:0][N-1:0]   b_row,
   output logic [M-1:0][N-1:0]   x_in,
   output logic [M-1:0][N-1:0]   y_in,
   output logic                  en,
   output logic                  busy,
   output logic                  done
);

   localparam int              CNT_W     = $clog2(2*M);
   localparam logic [CNT_W-1:0] FLUSH_END = CNT_W'(2*M-2);

   // Q only describes the number format of the words passing through
   if (Q < 0 || Q >= N) begin : g_bad_q
      $error("systolic_feeder: Q must lie in [0, N-1]");
   end

   state_t             state_q, state_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic               fire;
   logic [M-1:0][N-1:0] x_load, y_load;

   // handshake, advance enable, status and next-state/flush-counter logic
   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      in_ready = rst && (state_q == ST_IDLE || state_q == ST_STREAM);
      fire     = in_valid && in_ready;
      en       = fire || (rst && state_q == ST_FLUSH);
      busy     = (state_q != ST_IDLE);
      done     = (state_q == ST_DONE);
      case (state_q)
         ST_IDLE, ST_STREAM: begin
            if (fire) begin
               if (in_last) begin
                  state_d = ST_FLUSH;
                  cnt_d   = '0;
               end else begin
                  state_d = ST_STREAM;
               end
            end
         end
         ST_FLUSH: begin
            if (cnt_q == FLUSH_END) begin
               state_d = ST_DONE;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         ST_DONE: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // accepted data enters the skew lines; flush shifts push zeros behind it
   always_comb begin
      x_load = fire ? a_col : '0;
      y_load = fire ? b_row : '0;
   end

   // FSM state and flush counter registers
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   // lane i is delayed by i+1 advances so element k meets its partner in PE(i,j)
   for (genvar i = 0; i < M; i++) begin : g_lane
      skew_line #(.DEPTH(i + 1), .N(N)) u_x_line (
         .clk   (clk),
         .rst   (rst),
         .shift (en),
         .d     (x_load[i]),
         .q     (x_in[i])
      );
      skew_line #(.DEPTH(i + 1), .N(N)) u_y_line (
         .clk   (clk),
         .rst   (rst),
         .shift (en),
         .d     (y_load[i]),
         .q     (y_in[i])
      );
   end

endmodule

// File: tb/tb_systolic_feeder.sv
// tb/tb_systolic_feeder.sv - directed self-checking bench for systolic_feeder
module tb_systolic_feeder;

   localparam int N = 32;
   localparam int M = 3;
   localparam int Q = 10;

   logic                clk;
   logic                rst;
   logic                in_valid;
   logic                in_ready;
   logic                in_last;
   logic [M-1:0][N-1:0] a_col;
   logic [M-1:0][N-1:0] b_row;
   logic [M-1:0][N-1:0] x_in;
   logic [M-1:0][N-1:0] y_in;
   logic                en;
   logic                busy;
   logic                done;

   int vectors    = 0;
   int miscompares = 0;
   int done_total = 0;

   systolic_feeder #(.N(N), .M(M), .Q(Q)) dut (
      .clk      (clk),
      .rst      (rst),
      .in_valid (in_valid),
      .in_ready (in_ready),
      .in_last  (in_last),
      .a_col    (a_col),
      .b_row    (b_row),
      .x_in     (x_in),
      .y_in     (y_in),
      .en       (en),
      .busy     (busy),
      .done     (done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (done) done_total++;
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
      vectors++;
      assert (obs === exp_v) else begin
         miscompares++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp_v);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // A[i][k] = 3*i+k+1 -> [[1,2,3],[4,5,6],[7,8,9]]
   function automatic logic [N-1:0] a_val(input int i, input int k);
      return N'(3*i + k + 1);
   endfunction

   // B[k][j] = 10*(k+1)+j+1
   function automatic logic [N-1:0] b_val(input int k, input int j);
      return N'(10*(k + 1) + j + 1);
   endfunction

   function automatic logic [M-1:0][N-1:0] col_a(input int k);
      logic [M-1:0][N-1:0] r;
      for (int i = 0; i < M; i++) r[i] = a_val(i, k);
      return r;
   endfunction

   function automatic logic [M-1:0][N-1:0] row_b(input int k);
      logic [M-1:0][N-1:0] r;
      for (int j = 0; j < M; j++) r[j] = b_val(k, j);
      return r;
   endfunction

   // Feeds one matrix pair of k_beats beats, with `bubble` idle cycles before beat 1,
   // optionally holding garbage on in_valid once all beats are in, and checks every lane.
   task automatic run_pair(input string name, input int k_beats, input int bubble, input bit hold_valid);
      int e      = 0;
      int beat   = 0;
      int bub    = 0;
      int en_n   = 0;
      int done_n = 0;
      int cyc    = 0;
      bit en_s;
      bit finished = 0;
      logic [M-1:0][N-1:0] px, py;
      logic [N-1:0] ex, ey;
      while (cyc < 100 && !finished) begin
         if (beat < k_beats && !(beat == 1 && bub < bubble)) begin
            in_valid = 1'b1;
            in_last  = (beat == k_beats - 1);
            a_col    = col_a(beat);
            b_row    = row_b(beat);
         end else if (beat < k_beats) begin
            in_valid = 1'b0;
            bub++;
         end else if (hold_valid) begin
            in_valid = 1'b1;
            in_last  = 1'b1;
            a_col    = {M{N'(32'hDEAD)}};
            b_row    = {M{N'(32'hBEEF)}};
         end else begin
            in_valid = 1'b0;
            in_last  = 1'b0;
         end
         #1;
         if (done) begin
            done_n++;
            chk({name, " en low in DONE"}, en, 1'b0);
            chk({name, " in_ready low in DONE"}, in_ready, 1'b0);
            in_valid = 1'b0;
            tick();
            chk({name, " done one cycle"}, done, 1'b0);
            chk({name, " busy clear after DONE"}, busy, 1'b0);
            finished = 1;
         end else begin
            if (beat >= k_beats && busy) begin
               chk({name, " in_ready low draining"}, in_ready, 1'b0);
            end
            if (beat == 1 && bub > 0 && bub <= bubble && !in_valid) begin
               chk({name, " en low in bubble"}, en, 1'b0);
            end
            en_s = en;
            if (in_valid && in_ready) beat++;
            px = x_in;
            py = y_in;
            tick();
            cyc++;
            if (en_s) begin
               e++;
               en_n++;
               for (int i = 0; i < M; i++) begin
                  int idx = e - 1 - i;
                  ex = (idx >= 0 && idx < k_beats) ? a_val(i, idx) : '0;
                  ey = (idx >= 0 && idx < k_beats) ? b_val(idx, i) : '0;
                  chk($sformatf("%s x_in[%0d] edge %0d", name, i, e), x_in[i], ex);
                  chk($sformatf("%s y_in[%0d] edge %0d", name, i, e), y_in[i], ey);
               end
            end else begin
               chk({name, " x_in hold"}, x_in, px);
               chk({name, " y_in hold"}, y_in, py);
            end
         end
      end
      chk({name, " completed in budget"}, finished, 1'b1);
      chk({name, " en cycle count"}, en_n, k_beats + 2*M - 1);
      chk({name, " done pulses"}, done_n, 1);
   endtask

   initial begin
      int done_before;
      rst      = 1'b0;
      in_valid = 1'b0;
      in_last  = 1'b0;
      a_col    = '0;
      b_row    = '0;
      #3;
      chk("reset x_in zero", x_in, '0);
      chk("reset y_in zero", y_in, '0);
      chk("reset en", en, 1'b0);
      chk("reset busy", busy, 1'b0);
      chk("reset done", done, 1'b0);
      in_valid = 1'b1;
      #1;
      chk("reset en with valid", en, 1'b0);
      in_valid = 1'b0;
      tick();
      rst = 1'b1;
      #1;
      chk("idle in_ready", in_ready, 1'b1);
      chk("idle busy", busy, 1'b0);

      run_pair("stream", 3, 0, 1'b0);
      run_pair("bubble", 3, 2, 1'b0);
      run_pair("single", 1, 0, 1'b0);
      run_pair("backpressure", 3, 0, 1'b1);

      // reset in the middle of streaming
      done_before = done_total;
      in_valid = 1'b1;
      in_last  = 1'b0;
      a_col    = col_a(0);
      b_row    = row_b(0);
      tick();
      a_col = col_a(1);
      b_row = row_b(1);
      tick();
      chk("mid-stream busy", busy, 1'b1);
      chk("mid-stream x_in[0]", x_in[0], a_val(0, 1));
      #2;
      rst = 1'b0;
      #1;
      chk("async reset x_in zero", x_in, '0);
      chk("async reset y_in zero", y_in, '0);
      chk("async reset en", en, 1'b0);
      chk("async reset busy", busy, 1'b0);
      chk("async reset done", done, 1'b0);
      tick();
      in_valid = 1'b0;
      rst = 1'b1;
      #1;

      // reset in the middle of flushing
      in_valid = 1'b1;
      in_last  = 1'b1;
      a_col    = col_a(0);
      b_row    = row_b(0);
      tick();
      in_valid = 1'b0;
      in_last  = 1'b0;
      tick();
      chk("mid-flush busy", busy, 1'b1);
      chk("mid-flush en", en, 1'b1);
      rst = 1'b0;
      #1;
      chk("flush reset x_in zero", x_in, '0);
      chk("flush reset busy", busy, 1'b0);
      tick();
      rst = 1'b1;
      #1;
      chk("no done pulse across resets", done_total, done_before);

      run_pair("after reset", 3, 0, 1'b0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/systolic_feeder.md
SYSTOLIC_FEEDER -- requirements
Module: systolic_feeder

Interface
REQ-001 Parameter N, default 32: data word width in bits (signed Q-format word, passed through unmodified).
REQ-002 Parameter M, default 3: systolic array dimension (number of lanes on each edge).
REQ-003 Parameter Q, default 10: fractional bits; carried for package consistency only, with no arithmetic use in this block.
REQ-004 clk  input  1  single clock; all state updates on the rising edge.
REQ-005 rst  input  1  asynchronous, active-low reset; asserted when low.
REQ-006 in_valid  input  1  a_col/b_row beat is valid.
REQ-007 in_ready  output  1  block accepts a beat this cycle.
REQ-008 in_last  input  1  marks the final beat (k = K-1) of the current matrix pair.
REQ-009 a_col  input  M x N signed  column k of A; element i is A[i][k].
REQ-010 b_row  input  M x N signed  row k of B; element j is B[k][j].
REQ-011 x_in  output  M x N signed  skewed row-edge stream to the systolic array.
REQ-012 y_in  output  M x N signed  skewed column-edge stream to the systolic array.
REQ-013 en  output  1  array advance enable; the array and all skew registers shift on the same edge.
REQ-014 busy  output  1  high whenever state is not IDLE.
REQ-015 done  output  1  one-cycle pulse when the flush completes.

Function
REQ-016 The FSM SHALL have exactly four states: IDLE, STREAM, FLUSH and DONE.
REQ-017 In IDLE and STREAM, in_ready SHALL be 1; in FLUSH and DONE, in_ready SHALL be 0.
REQ-018 A beat SHALL be accepted when in_valid && in_ready.
REQ-019 The first accepted beat SHALL move the FSM from IDLE to STREAM, or to FLUSH if in_last is set.
REQ-020 In STREAM, a beat accepted with in_last=1 SHALL move the FSM to FLUSH.
REQ-021 en SHALL be combinational and equal to (beat accepted) || (state==FLUSH).
REQ-022 When en=0, no skew register and no counter SHALL change, so an input bubble stalls the array without corrupting alignment.
REQ-023 Lane i of the x and y paths SHALL be a shift line of i+1 registers that shifts only when en=1.
REQ-024 Each shift line SHALL load a_col[i] (or b_row[i]) when a beat is accepted, and signed zero when shifting in FLUSH.
REQ-025 x_in[i] and y_in[i] SHALL be the last stage of their line, so element k of lane i appears after i+1 en-edges from its acceptance.
REQ-026 FLUSH SHALL last exactly 2*M-1 en cycles, counted by a counter of width $clog2(2*M) that resets to 0 on entry.
REQ-027 After the last FLUSH cycle the FSM SHALL enter DONE; DONE SHALL assert done=1 and en=0 for one cycle, then return to IDLE.
REQ-028 Inputs presented in FLUSH or DONE SHALL be ignored, since in_ready=0.
REQ-029 A beat presented in IDLE while DONE is completing SHALL not be possible, because DONE lasts one cycle with in_ready=0.
REQ-030 No arithmetic SHALL be performed; values SHALL pass bit-exact from input to output.

Reset
REQ-031 While rst=0, independent of clk, the block SHALL be in state IDLE with all skew registers 0, the flush counter 0, and done=0, busy=0, en=0.
REQ-032 Reset asserted mid-STREAM or mid-FLUSH SHALL discard all in-flight data with no done pulse.
REQ-033 After reset deasserts, the first accepted beat SHALL start a fresh matrix pair.

Structure
REQ-034 Package systolic_pkg SHALL hold N, M and Q defaults, a word_t typedef (logic signed [N-1:0]) and the FSM state enum.
REQ-035 A single sub-module, skew_line (parameters DEPTH and N; ports clk, rst, shift, d, q), SHALL be instantiated 2*M times with DEPTH=i+1.

Verification
REQ-036 Reset check: rst=0 mid-run -> all x_in/y_in=0, en=0, busy=0 immediately, before the next clk edge.
REQ-037 Streaming check: M=3, A=[[1,2,3],[4,5,6],[7,8,9]], three back-to-back beats with last on k=2.
- x_in[0] over en-edges SHALL read 1,2,3,0...
- x_in[1] SHALL read 0,4,5,6,0...
- x_in[2] SHALL read 0,0,7,8,9,0...
- en SHALL be high for 3+5 cycles, and done SHALL pulse once.
REQ-038 Bubble check: deassert in_valid for 2 cycles between k=0 and k=1.
- en=0 for those cycles and all outputs SHALL hold.
- The resulting sequence SHALL be identical to the no-bubble case.
REQ-039 Single-beat matrix: one beat with in_last=1 -> FLUSH entered directly, en high 1+5 cycles, done pulse.
REQ-040 Backpressure check: in_valid held high during FLUSH -> in_ready=0, no beat consumed, and x_in shows only zeros after the data drains.
REQ-041 End-to-end check: feeder plus systolic_array with A as in REQ-037 and B=identity -> acc_sum equals A after done.
